// File: rtl/glyph_reader_pkg.sv
// glyph_reader_pkg
// Shared types and helpers for the glyph reader:
//   state_t   - recogniser FSM states
//   idx_width - index width for a pattern of n entries (never below 1)
//   is_blank  - true when a sampled column has no set rows
package glyph_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MATCH = 2'd1,
        SKIP  = 2'd2
    } state_t;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Columns are zero-extended by the caller so one function serves any ROWS.
    function automatic logic is_blank(input logic [63:0] c);
        return (c == 64'd0);
    endfunction

endpackage

// File: rtl/glyph_reader_if.sv
// glyph_reader_if
// Column stream, pattern/length programming and result signals.
//   master : drives col_valid/col and the programming fields, observes results
//   slave  : the reader; observes the stream/programming, drives match/busy/match_count
interface glyph_reader_if #(
    parameter int ROWS    = 3,
    parameter int MAX_LEN = 4,
    parameter int COUNT_W = 8
);
    localparam int IDX_W = glyph_reader_pkg::idx_width(MAX_LEN);

    logic               col_valid;
    logic [ROWS-1:0]    col;
    logic               pat_we;
    logic [IDX_W-1:0]   pat_idx;
    logic [ROWS-1:0]    pat_col;
    logic               len_we;
    logic [IDX_W:0]     len_val;
    logic               match;
    logic               busy;
    logic [COUNT_W-1:0] match_count;

    modport master (
        output col_valid, col, pat_we, pat_idx, pat_col, len_we, len_val,
        input  match, busy, match_count
    );

    modport slave (
        input  col_valid, col, pat_we, pat_idx, pat_col, len_we, len_val,
        output match, busy, match_count
    );
endinterface

// File: rtl/glyph_pattern_store.sv
// glyph_pattern_store
// Holds the programmed glyph columns and the glyph length.
//   clk, restart        - clock, synchronous active-low reset
//   pat_we/pat_idx/pat_col - pattern entry write (out-of-range index ignored)
//   len_we/len_val      - length write, clamped to MAX_LEN
//   pattern, pat_len    - current contents
//   cfg_write           - an accepted write happens this cycle
module glyph_pattern_store #(
    parameter int ROWS    = 3,
    parameter int MAX_LEN = 4,
    parameter int IDX_W   = 2
) (
    input  logic                          clk,
    input  logic                          restart,
    input  logic                          pat_we,
    input  logic [IDX_W-1:0]              pat_idx,
    input  logic [ROWS-1:0]               pat_col,
    input  logic                          len_we,
    input  logic [IDX_W:0]                len_val,
    output logic [MAX_LEN-1:0][ROWS-1:0]  pattern,
    output logic [IDX_W:0]                pat_len,
    output logic                          cfg_write
);
    localparam logic [IDX_W:0] LEN_MAX = (IDX_W+1)'(MAX_LEN);

    logic pat_ok;

    assign pat_ok    = pat_we && ({1'b0, pat_idx} < LEN_MAX);
    assign cfg_write = pat_ok || len_we;

    always_ff @(posedge clk) begin
        if (!restart) begin
            pattern <= '0;
            pat_len <= '0;
        end else begin
            if (pat_ok)
                pattern[pat_idx] <= pat_col;
            if (len_we)
                pat_len <= (len_val > LEN_MAX) ? LEN_MAX : len_val;
        end
    end
endmodule

// File: rtl/glyph_reader.sv
// glyph_reader
// Recognises a programmed glyph (pat_len non-blank columns between blanks)
// in a stream of sampled columns and counts recognitions.
//   clk, restart - clock, synchronous active-low reset
//   bus (slave)  - column stream, programming, match/busy/match_count
//
//   state | meaning
//   IDLE  | previous column blank (or just reset); idx = 0
//   MATCH | idx leading columns of the glyph matched
//   SKIP  | mismatch or reprogramming; waiting for a blank
module glyph_reader
    import glyph_reader_pkg::*;
#(
    parameter int ROWS    = 3,
    parameter int MAX_LEN = 4,
    parameter int COUNT_W = 8
) (
    input  logic           clk,
    input  logic           restart,
    glyph_reader_if.slave  bus
);
    localparam int IDX_W = idx_width(MAX_LEN);

    logic [MAX_LEN-1:0][ROWS-1:0] pattern;
    logic [IDX_W:0]               pat_len;
    logic                         cfg_write;

    state_t             state;
    logic [IDX_W:0]     idx;
    logic               match_r;
    logic               busy_r;
    logic [COUNT_W-1:0] count_r;

    logic blank;
    logic hit;

    glyph_pattern_store #(
        .ROWS   (ROWS),
        .MAX_LEN(MAX_LEN),
        .IDX_W  (IDX_W)
    ) u_store (
        .clk      (clk),
        .restart  (restart),
        .pat_we   (bus.pat_we),
        .pat_idx  (bus.pat_idx),
        .pat_col  (bus.pat_col),
        .len_we   (bus.len_we),
        .len_val  (bus.len_val),
        .pattern  (pattern),
        .pat_len  (pat_len),
        .cfg_write(cfg_write)
    );

    assign blank = is_blank(64'(bus.col));
    // idx is 0 in IDLE, so this one compare covers the first column too;
    // idx < pat_len also keeps the index inside the pattern array.
    assign hit   = (idx < pat_len) && (bus.col == pattern[idx[IDX_W-1:0]]);

    always_ff @(posedge clk) begin
        if (!restart) begin
            state   <= IDLE;
            idx     <= '0;
            match_r <= 1'b0;
            busy_r  <= 1'b0;
            count_r <= '0;
        end else begin
            match_r <= 1'b0;
            if (cfg_write) begin
                // Reprogramming invalidates any partial glyph; the column is dropped.
                state  <= SKIP;
                idx    <= '0;
                busy_r <= 1'b0;
            end else if (bus.col_valid) begin
                case (state)
                    IDLE, MATCH: begin
                        if (blank) begin
                            if (state == MATCH && idx == pat_len) begin
                                match_r <= 1'b1;
                                if (count_r != '1)
                                    count_r <= count_r + COUNT_W'(1);
                            end
                            state  <= IDLE;
                            idx    <= '0;
                            busy_r <= 1'b0;
                        end else if (hit) begin
                            state  <= MATCH;
                            idx    <= idx + (IDX_W+1)'(1);
                            busy_r <= 1'b1;
                        end else begin
                            state  <= SKIP;
                            idx    <= '0;
                            busy_r <= 1'b0;
                        end
                    end
                    SKIP: begin
                        if (blank)
                            state <= IDLE;
                    end
                    default: begin
                        state  <= IDLE;
                        idx    <= '0;
                        busy_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.match       = match_r;
    assign bus.busy        = busy_r;
    assign bus.match_count = count_r;
endmodule

// File: tb/tb_glyph_reader.sv
module tb_glyph_reader;

    logic clk = 1'b0;
    logic restart = 1'b0;

    always #5 clk = ~clk;

    glyph_reader_if #(.ROWS(3), .MAX_LEN(4), .COUNT_W(8)) ifa ();
    glyph_reader_if #(.ROWS(3), .MAX_LEN(4), .COUNT_W(2)) ifb ();

    glyph_reader #(.ROWS(3), .MAX_LEN(4), .COUNT_W(8)) dut (
        .clk    (clk),
        .restart(restart),
        .bus    (ifa.slave)
    );

    glyph_reader #(.ROWS(3), .MAX_LEN(4), .COUNT_W(2)) dut2 (
        .clk    (clk),
        .restart(restart),
        .bus    (ifb.slave)
    );

    // Second DUT (narrow counter) sees exactly the same stimulus.
    assign ifb.col_valid = ifa.col_valid;
    assign ifb.col       = ifa.col;
    assign ifb.pat_we    = ifa.pat_we;
    assign ifb.pat_idx   = ifa.pat_idx;
    assign ifb.pat_col   = ifa.pat_col;
    assign ifb.len_we    = ifa.len_we;
    assign ifb.len_val   = ifa.len_val;

    typedef struct {
        int cyc;
        int c8;
        int c2;
    } exp_t;

    exp_t sb[$];
    exp_t e_pop;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   m8    = 0;
    int   m2    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every match pulse must correspond to a queued expectation.
    always @(negedge clk) begin
        if (ifa.match) begin
            if (sb.size() == 0) begin
                check("unexpected match", int'(ifa.match), 0);
            end else begin
                e_pop = sb.pop_front();
                check("match cycle", cyc, e_pop.cyc);
                check("match_count", int'(ifa.match_count), e_pop.c8);
                check("match (COUNT_W=2)", int'(ifb.match), 1);
                check("match_count (COUNT_W=2)", int'(ifb.match_count), e_pop.c2);
            end
        end else if (ifb.match) begin
            check("stray match (COUNT_W=2)", int'(ifb.match), 0);
        end
    end

    task automatic clear_inputs();
        ifa.col_valid = 1'b0;
        ifa.col       = 3'b000;
        ifa.pat_we    = 1'b0;
        ifa.pat_idx   = 2'd0;
        ifa.pat_col   = 3'b000;
        ifa.len_we    = 1'b0;
        ifa.len_val   = 3'd0;
    endtask

    // One valid column; em = this column terminates a glyph (expect a pulse).
    task automatic col(input logic [2:0] c, input logic eb, input logic em);
        ifa.col_valid = 1'b1;
        ifa.col       = c;
        if (em) begin
            m8++;
            m2 = (m2 < 3) ? m2 + 1 : 3;
            sb.push_back('{cyc + 1, m8, m2});
        end
        @(posedge clk);
        #1;
        ifa.col_valid = 1'b0;
        check($sformatf("busy after col %b", c), int'(ifa.busy), int'(eb));
    endtask

    task automatic gap(input int n, input logic eb);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("busy held in gap", int'(ifa.busy), int'(eb));
        end
    endtask

    task automatic wr(input logic [1:0] pidx, input logic [2:0] pcol, input logic pwe,
                      input logic lwe, input logic [2:0] len,
                      input logic cv, input logic [2:0] c);
        ifa.pat_we    = pwe;
        ifa.pat_idx   = pidx;
        ifa.pat_col   = pcol;
        ifa.len_we    = lwe;
        ifa.len_val   = len;
        ifa.col_valid = cv;
        ifa.col       = c;
        @(posedge clk);
        #1;
        clear_inputs();
        check("busy after cfg write", int'(ifa.busy), 0);
    endtask

    // 111,001 with len 2; first write also sets the length in the same cycle.
    task automatic program_default();
        wr(2'd0, 3'b111, 1'b1, 1'b1, 3'd2, 1'b0, 3'b000);
        wr(2'd1, 3'b001, 1'b1, 1'b0, 3'd0, 1'b0, 3'b000);
    endtask

    // Reset asserted together with writes and a column: reset must win.
    task automatic do_reset();
        restart       = 1'b0;
        ifa.col_valid = 1'b1;
        ifa.col       = 3'b001;
        ifa.pat_we    = 1'b1;
        ifa.pat_idx   = 2'd0;
        ifa.pat_col   = 3'b111;
        ifa.len_we    = 1'b1;
        ifa.len_val   = 3'd2;
        @(posedge clk);
        #1;
        restart = 1'b1;
        clear_inputs();
        m8 = 0;
        m2 = 0;
        check("reset match", int'(ifa.match), 0);
        check("reset busy", int'(ifa.busy), 0);
        check("reset match_count", int'(ifa.match_count), 0);
        check("reset match_count (COUNT_W=2)", int'(ifb.match_count), 0);
    endtask

    initial begin
        clear_inputs();
        restart = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Basic glyph
        program_default();
        col(3'b000, 0, 0); col(3'b111, 1, 0); col(3'b001, 1, 0); col(3'b000, 0, 1);

        // Over-long glyph rejected, then a clean one
        do_reset(); program_default();
        col(3'b000, 0, 0); col(3'b111, 1, 0); col(3'b001, 1, 0); col(3'b001, 0, 0);
        col(3'b000, 0, 0); col(3'b111, 1, 0); col(3'b001, 1, 0); col(3'b000, 0, 1);

        // Back-to-back, then with col_valid gaps
        do_reset(); program_default();
        col(3'b000, 0, 0); col(3'b111, 1, 0); col(3'b001, 1, 0); col(3'b000, 0, 1);
        col(3'b111, 1, 0); col(3'b001, 1, 0); col(3'b000, 0, 1);
        col(3'b111, 1, 0); gap(2, 1); col(3'b001, 1, 0); gap(3, 1); col(3'b000, 0, 1);
        gap(1, 0); col(3'b111, 1, 0); col(3'b001, 1, 0); gap(2, 1); col(3'b000, 0, 1);

        // Reset mid-glyph: no pulse, pattern cleared until reprogrammed
        do_reset(); program_default();
        col(3'b000, 0, 0); col(3'b111, 1, 0);
        do_reset();
        col(3'b111, 0, 0); col(3'b001, 0, 0); col(3'b000, 0, 0);
        program_default();
        col(3'b000, 0, 0); col(3'b111, 1, 0); col(3'b001, 1, 0); col(3'b000, 0, 1);

        // Write during MATCH forces SKIP; concurrent column discarded
        do_reset(); program_default();
        col(3'b000, 0, 0); col(3'b111, 1, 0);
        wr(2'd1, 3'b001, 1'b1, 1'b0, 3'd0, 1'b1, 3'b001);
        col(3'b001, 0, 0); col(3'b000, 0, 0);
        col(3'b111, 1, 0); col(3'b001, 1, 0); col(3'b000, 0, 1);

        // Length clamp: 7 -> 4, full-length glyph; short one rejected
        do_reset(); program_default();
        wr(2'd2, 3'b010, 1'b1, 1'b1, 3'd7, 1'b0, 3'b000);
        wr(2'd3, 3'b100, 1'b1, 1'b0, 3'd0, 1'b0, 3'b000);
        col(3'b000, 0, 0); col(3'b111, 1, 0); col(3'b001, 1, 0); col(3'b010, 1, 0);
        col(3'b100, 1, 0); col(3'b000, 0, 1);
        col(3'b111, 1, 0); col(3'b001, 1, 0); col(3'b010, 1, 0); col(3'b000, 0, 0);

        // Saturation of the 2-bit counter over five glyphs
        do_reset(); program_default();
        col(3'b000, 0, 0);
        for (int i = 0; i < 5; i++) begin
            col(3'b111, 1, 0); col(3'b001, 1, 0); col(3'b000, 0, 1);
        end

        gap(2, 0);
        check("final match_count", int'(ifa.match_count), 5);
        check("final match_count (COUNT_W=2)", int'(ifb.match_count), 3);
        check("missing match pulses", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/glyph_reader.md
GLYPH_READER -- requirements
Module: glyph_reader

Interface
REQ-001 Parameter ROWS, 3, bits per sampled column.
REQ-002 Parameter MAX_LEN, 4, maximum non-blank columns in a programmed glyph.
REQ-003 Parameter COUNT_W, 8, width of match_count.
REQ-004 Derived IDX_W = clog2(MAX_LEN), minimum 1.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 restart  in  1  reset, synchronous, active-low: restart=0 at a rising edge resets the block.
REQ-007 col_valid  in  1  col is sampled this cycle.
REQ-008 col  in  ROWS  column under test; all-zero = blank.
REQ-009 pat_we  in  1  write pat_col into pattern entry pat_idx.
REQ-010 pat_idx  in  IDX_W  pattern entry index.
REQ-011 pat_col  in  ROWS  pattern column data.
REQ-012 len_we  in  1  write len_val into the glyph length register.
REQ-013 len_val  in  IDX_W+1  glyph length, 0..MAX_LEN.
REQ-014 match  out  1  one-cycle pulse per recognised glyph.
REQ-015 busy  out  1  high while in MATCH state.
REQ-016 match_count  out  COUNT_W  saturating count of matches.

Function
REQ-017 Glyph = pat_len non-blank columns pattern[0..pat_len-1] in order, preceded by a blank (or reset) and terminated by one blank.
REQ-018 States IDLE (previous column blank), MATCH (idx columns matched), SKIP (mismatch; waiting for blank); only col_valid=1 cycles advance the FSM.
REQ-019 IDLE: col==pattern[0] -> MATCH idx=1; blank -> IDLE; else -> SKIP.
REQ-020 MATCH, idx<pat_len: col==pattern[idx] -> idx+1; blank -> IDLE; else -> SKIP.
REQ-021 MATCH, idx==pat_len: blank -> match pulse, IDLE; non-blank -> SKIP.
REQ-022 SKIP: blank -> IDLE; else SKIP.
REQ-023 Blank check takes priority over pattern compare; a zero pattern entry is therefore unmatchable.
REQ-024 match is registered: high for exactly the one cycle after the edge that samples the terminating blank; the terminating blank also serves as the leading blank of the next glyph (back-to-back matches allowed).
REQ-025 pat_len==0 disables recognition: FSM does not leave IDLE/SKIP; match stays 0.
REQ-026 len_val>MAX_LEN is clamped to MAX_LEN; pat_we with pat_idx>=MAX_LEN is ignored.
REQ-027 Any accepted pat_we or len_we forces state to SKIP and idx to 0 on the same edge; a simultaneous col_valid column is discarded.
REQ-028 pat_we and len_we in the same cycle both take effect.
REQ-029 match_count increments on each match pulse and holds at 2^COUNT_W-1.
REQ-030 col_valid=0 cycles hold state, idx and match_count; match is 0.

Reset
REQ-031 On restart=0: state IDLE, idx 0, match 0, busy 0, match_count 0, pat_len 0, all pattern entries 0.
REQ-032 Reset mid-glyph abandons the partial match with no match pulse; reset overrides simultaneous pat_we/len_we/col_valid.

Structure
REQ-033 Package glyph_reader_pkg holds the state enum {IDLE, MATCH, SKIP} and the blank-column constant function.
REQ-034 Pattern storage plus length register with clamping lives in sub-module glyph_pattern_store; FSM and counter in glyph_reader.

Verification (ROWS=3, MAX_LEN=4; program 111,001, len 2 after reset unless noted)
REQ-035 Columns 000,111,001,000 all valid -> match=1 for one cycle after last edge, busy high for 2 cycles, match_count=1.
REQ-036 Columns 111,001,001,000 -> no match; then 111,001,000 -> one match, count=1.
REQ-037 Columns 111,001,000,111,001,000 -> two match pulses, count=2; with col_valid=0 gaps inserted -> same two pulses, each one cycle after its terminating blank.
REQ-038 restart=0 for one cycle after 111 -> no match; subsequent 111,001,000 -> no match (pat_len 0) until reprogrammed.
REQ-039 pat_we during MATCH after 111 -> state SKIP; following 001,000 -> no match.
REQ-040 COUNT_W=2, five valid glyphs -> five match pulses, match_count saturates at 3.
